paddle_ctrl: RTL and testbench

PADDLE_CTRL -- requirements
Module: paddle_ctrl

---
 rtl/paddle_if.sv | 53 +++++
 rtl/paddle_ctrl.sv | 140 ++++++++++++++
 tb/tb_paddle_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/paddle_if.sv
// paddle_if -- bundles the per-frame control inputs and the paddle geometry
// outputs of paddle_ctrl.
//
// Ports (through modports):
//   in_ani_stb     one-cycle animation strobe, one per frame
//   in_animate     state updates only while high
//   in_button_up   manual move up request
//   in_button_down manual move down request
//   in_mode_auto   1 = track in_ball_y, 0 = buttons
//   in_ball_y      ball centre y for auto mode (12 bits)
//   out_x1/out_x2  paddle left/right edge (12 bits each)
//   out_y1/out_y2  paddle top/bottom edge (12 bits each)
//   out_moving     FSM is in MOVE
//   out_at_top     y sits on the upper clamp
//   out_at_bottom  y sits on the lower clamp
//   dbg_*          internal state (FSM, direction, speed, hold counter)
//
// Handshake: in_ani_stb is the only qualifier. A cycle with in_ani_stb=1 and
// in_animate=1 is an update; the block is always ready, so every such cycle
// is consumed immediately and nothing is ever back-pressured.
interface paddle_if;
  logic        in_ani_stb;
  logic        in_animate;
  logic        in_button_up;
  logic        in_button_down;
  logic        in_mode_auto;
  logic [11:0] in_ball_y;
  logic [11:0] out_x1;
  logic [11:0] out_x2;
  logic [11:0] out_y1;
  logic [11:0] out_y2;
  logic        out_moving;
  logic        out_at_top;
  logic        out_at_bottom;
  logic        dbg_state;
  logic        dbg_dir;
  logic [7:0]  dbg_speed;
  logic [7:0]  dbg_counter;

  modport master (
    output in_ani_stb, in_animate, in_button_up, in_button_down,
           in_mode_auto, in_ball_y,
    input  out_x1, out_x2, out_y1, out_y2, out_moving, out_at_top,
           out_at_bottom, dbg_state, dbg_dir, dbg_speed, dbg_counter
  );

  modport slave (
    input  in_ani_stb, in_animate, in_button_up, in_button_down,
           in_mode_auto, in_ball_y,
    output out_x1, out_x2, out_y1, out_y2, out_moving, out_at_top,
           out_at_bottom, dbg_state, dbg_dir, dbg_speed, dbg_counter
  );
endinterface

// File: rtl/paddle_ctrl.sv
// paddle_ctrl -- vertical paddle with accelerating button/auto movement.
//
// Ports:
//   in_clock    single clock, all state on its rising edge
//   in_reset_n  synchronous active-low reset
//   bus         paddle_if.slave: frame strobe, controls, geometry outputs
//
// Each update (strobe while animating) computes a requested direction, runs
// the IDLE/MOVE speed ramp, and moves y by direction*speed using the speed
// just computed. Hitting a clamp drops the ramp back to IDLE.
module paddle_ctrl #(
  parameter int H_SIZE       = 10,
  parameter int V_SIZE       = 90,
  parameter int IX           = 10,
  parameter int IY           = 240,
  parameter int MAX_SPEED    = 6,
  parameter int ACCEL_FRAMES = 4,
  parameter int TOP_MARGIN   = 5,
  parameter int AI_DEADZONE  = 8,
  parameter int D_WIDTH      = 639,
  parameter int D_HEIGHT     = 470
) (
  input  logic     in_clock,
  input  logic     in_reset_n,
  paddle_if.slave  bus
);
  localparam int YMIN = V_SIZE + TOP_MARGIN;
  localparam int YMAX = D_HEIGHT - V_SIZE - 1;
  localparam int SW   = $clog2(MAX_SPEED + 1);
  localparam int CW   = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

  localparam logic signed [13:0] YMIN_S = 14'(YMIN);
  localparam logic signed [13:0] YMAX_S = 14'(YMAX);
  localparam logic signed [13:0] DZ_S   = 14'(AI_DEADZONE);
  localparam logic [SW-1:0]      SPD_MAX = SW'(MAX_SPEED);
  localparam logic [CW-1:0]      CNT_MAX = CW'(ACCEL_FRAMES - 1);

  typedef enum logic {IDLE = 1'b0, MOVE = 1'b1} state_t;

  state_t        state_q, state_d;
  logic          dir_q, dir_d;        // 1 = +1 (down the screen), 0 = -1
  logic [SW-1:0] speed_q, speed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   x_q, y_q, y_d;

  logic               req_up, req_dn;
  logic signed [13:0] y_s, ball_s, spd_s, y_sum;

  assign y_s    = $signed({2'b00, y_q});
  assign ball_s = $signed({2'b00, bus.in_ball_y});

  // Requested direction; buttons are ignored entirely in auto mode.
  always_comb begin
    req_up = 1'b0;
    req_dn = 1'b0;
    if (bus.in_mode_auto) begin
      req_dn = ball_s > (y_s + DZ_S);
      req_up = (ball_s + DZ_S) < y_s;
    end else begin
      req_dn = bus.in_button_down & ~bus.in_button_up;
      req_up = bus.in_button_up & ~bus.in_button_down;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    speed_d = speed_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    spd_s   = '0;
    y_sum   = y_s;

    if (!req_up && !req_dn) begin
      state_d = IDLE;
      speed_d = '0;
      cnt_d   = '0;
    end else if (state_q == IDLE || req_dn != dir_q) begin
      // Fresh start or reversal: restart the ramp in the new direction.
      state_d = MOVE;
      dir_d   = req_dn;
      speed_d = SW'(1);
      cnt_d   = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      if (speed_q != SPD_MAX) speed_d = speed_q + SW'(1);
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    // Position uses the speed computed in this same update.
    spd_s = $signed(14'(speed_d));
    y_sum = dir_d ? (y_s + spd_s) : (y_s - spd_s);

    if (y_sum > YMAX_S) begin
      y_d     = 12'(YMAX);
      state_d = IDLE;
      speed_d = '0;
      cnt_d   = '0;
    end else if (y_sum < YMIN_S) begin
      y_d     = 12'(YMIN);
      state_d = IDLE;
      speed_d = '0;
      cnt_d   = '0;
    end else begin
      y_d = y_sum[11:0];
    end
  end

  always_ff @(posedge in_clock) begin
    if (!in_reset_n) begin
      x_q     <= 12'(IX);
      y_q     <= 12'(IY);
      state_q <= IDLE;
      dir_q   <= 1'b1;
      speed_q <= '0;
      cnt_q   <= '0;
    end else if (bus.in_animate && bus.in_ani_stb) begin
      x_q     <= x_q;
      y_q     <= y_d;
      state_q <= state_d;
      dir_q   <= dir_d;
      speed_q <= speed_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_x1        = x_q - 12'(H_SIZE);
  assign bus.out_x2        = x_q + 12'(H_SIZE);
  assign bus.out_y1        = y_q - 12'(V_SIZE);
  assign bus.out_y2        = y_q + 12'(V_SIZE);
  assign bus.out_moving    = (state_q == MOVE);
  assign bus.out_at_top    = (y_q == 12'(YMIN));
  assign bus.out_at_bottom = (y_q == 12'(YMAX));

  assign bus.dbg_state   = state_q;
  assign bus.dbg_dir     = dir_q;
  assign bus.dbg_speed   = 8'(speed_q);
  assign bus.dbg_counter = 8'(cnt_q);
endmodule

// File: tb/tb_paddle_ctrl.sv
module tb_paddle_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  paddle_if bus ();

  paddle_ctrl dut (
    .in_clock   (clk),
    .in_reset_n (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Centre y recovered from the top edge (V_SIZE = 90).
  task automatic chk_y(input string tag, input int exp);
    chk(tag, 32'(bus.out_y1), 32'(exp - 90));
  endtask

  // One update: strobe high for exactly one rising edge; checks happen at the
  // following falling edge.
  task automatic upd(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) bus.in_ani_stb = 1'b1;
      @(negedge clk) bus.in_ani_stb = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic set_btn(input logic up, input logic dn);
    bus.in_button_up   = up;
    bus.in_button_down = dn;
  endtask

  initial begin
    int exp5[5];
    exp5 = '{241, 242, 243, 244, 246};

    bus.in_ani_stb   = 1'b0;
    bus.in_animate   = 1'b1;
    bus.in_mode_auto = 1'b0;
    bus.in_ball_y    = 12'd0;
    set_btn(1'b0, 1'b0);

    // Reset state
    do_reset();
    chk("rst_x1", 32'(bus.out_x1), 0);
    chk("rst_x2", 32'(bus.out_x2), 20);
    chk("rst_y1", 32'(bus.out_y1), 150);
    chk("rst_y2", 32'(bus.out_y2), 330);
    chk("rst_moving", 32'(bus.out_moving), 0);
    chk("rst_top", 32'(bus.out_at_top), 0);
    chk("rst_bot", 32'(bus.out_at_bottom), 0);
    chk("rst_speed", 32'(bus.dbg_speed), 0);
    chk("rst_dir", 32'(bus.dbg_dir), 1);

    // Hold down for five updates
    set_btn(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      upd(1);
      chk_y("down5_y", exp5[i]);
      chk("down5_moving", 32'(bus.out_moving), 1);
    end

    // Hold down for 40 updates: ramp to 6, then bottom clamp
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      upd(1);
      if (i == 20) begin
        chk_y("ramp_y20", 300);
        chk("ramp_spd20", 32'(bus.dbg_speed), 5);
      end
      if (i == 21) chk("ramp_spd21", 32'(bus.dbg_speed), 6);
      if (i == 33) begin
        chk_y("ramp_y33", 378);
        chk("ramp_mov33", 32'(bus.out_moving), 1);
      end
      if (i == 34) begin
        chk_y("ramp_y34", 379);
        chk("ramp_mov34", 32'(bus.out_moving), 0);
      end
      if (i == 35) chk_y("ramp_y35", 379);
    end
    chk_y("bot_y", 379);
    chk("bot_at_bottom", 32'(bus.out_at_bottom), 1);
    chk("bot_moving", 32'(bus.out_moving), 0);
    chk("bot_y2", 32'(bus.out_y2), 469);

    // Reset coincident with an update while moving at y=300
    do_reset();
    upd(20);
    chk_y("rmove_y", 300);
    chk("rmove_moving", 32'(bus.out_moving), 1);
    @(negedge clk) begin
      rst_n = 1'b0;
      bus.in_ani_stb = 1'b1;
    end
    @(negedge clk) begin
      rst_n = 1'b1;
      bus.in_ani_stb = 1'b0;
    end
    chk_y("rcoin_y", 240);
    chk("rcoin_moving", 32'(bus.out_moving), 0);
    chk("rcoin_speed", 32'(bus.dbg_speed), 0);
    upd(1);
    chk_y("rrel_y", 241);
    chk("rrel_speed", 32'(bus.dbg_speed), 1);

    // Reversal after six updates down
    do_reset();
    upd(6);
    chk_y("rev_y6", 248);
    set_btn(1'b1, 1'b0);
    upd(1);
    chk_y("rev_y", 247);
    chk("rev_speed", 32'(bus.dbg_speed), 1);
    chk("rev_cnt", 32'(bus.dbg_counter), 0);
    chk("rev_dir", 32'(bus.dbg_dir), 0);

    // Both buttons held: stop
    set_btn(1'b1, 1'b1);
    upd(1);
    chk_y("both_y", 247);
    chk("both_moving", 32'(bus.out_moving), 0);

    // Strobes while not animating
    set_btn(1'b1, 1'b0);
    bus.in_animate = 1'b0;
    upd(3);
    chk_y("noanim_y", 247);
    chk("noanim_moving", 32'(bus.out_moving), 0);

    // Animating but no strobe
    bus.in_animate = 1'b1;
    repeat (6) @(negedge clk);
    chk_y("nostb_y", 247);
    chk("nostb_moving", 32'(bus.out_moving), 0);

    // Hold up for 40 updates: top clamp
    do_reset();
    upd(34);
    chk_y("top_y34", 96);
    upd(1);
    chk_y("top_y35", 95);
    chk("top_at_top", 32'(bus.out_at_top), 1);
    chk("top_moving", 32'(bus.out_moving), 0);
    upd(5);
    chk_y("top_y40", 95);
    chk("top_y1", 32'(bus.out_y1), 5);

    // Auto mode tracking ball at 300; the up button is ignored
    do_reset();
    bus.in_mode_auto = 1'b1;
    bus.in_ball_y = 12'd300;
    set_btn(1'b1, 1'b0);
    upd(1);
    chk_y("auto_y1", 241);
    upd(18);
    chk_y("auto_y19", 295);
    chk("auto_mov19", 32'(bus.out_moving), 1);
    upd(1);
    chk_y("auto_y20", 295);
    chk("auto_mov20", 32'(bus.out_moving), 0);

    // Auto mode inside the dead zone; the down button is ignored
    do_reset();
    bus.in_ball_y = 12'd245;
    set_btn(1'b0, 1'b1);
    upd(3);
    chk_y("dz_y", 240);
    chk("dz_moving", 32'(bus.out_moving), 0);

    // Mode change back to buttons takes effect at the next update
    bus.in_mode_auto = 1'b0;
    upd(1);
    chk_y("mode_y", 241);
    chk("mode_moving", 32'(bus.out_moving), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
